ks10_bus_arb: RTL and testbench
===============================

// Module: ks10_bus_arb
//
// PURPOSE
//  Parametrised multi-master bus arbiter for the KS10 backplane.
//  It generalises the fixed CPU/console/Unibus arbiter to NUM_MST masters, with a
//  selectable fixed-priority or round-robin policy and a registered address/data path.
//  A no-ack timeout turns a dead cycle into an NXM (non-existent memory) completion.
//  It sits between the bus masters (CPU, CSL, UBA adapters) and the shared target
//  side (MEM plus the device address decoders).
//
// PARAMETERS
//  NUM_MST   4   number of bus masters, 2..8; master 0 = CPU
//  ADDR_W   36   address width per master
//  DATA_W   36   data width per master
//  RR_MODE   1   0 = fixed priority (lowest index wins); 1 = round-robin
//  TIMEOUT  64   cycles to wait for arbACKI before NXM; 0 = never time out
//
// PORTS
//  clk       in   1               system clock; all state changes on rising edge
//  rst_N     in   1               asynchronous, active-low reset
//  busREQI   in   NUM_MST         per-master request, level, held until its ACK
//  busACKO   out  NUM_MST         per-master acknowledge, one-cycle pulse
//  busADDRI  in   NUM_MST*ADDR_W  master addresses; master i at [i*ADDR_W +: ADDR_W]
//  busDATAI  in   NUM_MST*DATA_W  master write data; same packing as busADDRI
//  busDATAO  out  DATA_W          read data returned to the granted master
//  arbREQO   out  1               request to the target side
//  arbACKI   in   1               target acknowledge
//  arbADDRO  out  ADDR_W          latched address of the granted master
//  arbDATAO  out  DATA_W          latched write data of the granted master
//  arbDATAI  in   DATA_W          target read data, valid with arbACKI
//  arbGNT    out  $clog2(NUM_MST) index of the current or last granted master
//  arbBUSY   out  1               high whenever state != IDLE
//  arbNXM    out  1               one-cycle pulse on a timed-out transaction
//
// BEHAVIOUR
//  Reset (async, rst_N=0):
//   - state=IDLE, rrPtr=0, timer=0.
//   - Every output is 0, including busDATAO, arbADDRO, arbDATAO and arbGNT.
//   - Reset mid-transaction aborts it immediately; no ACK or NXM is issued.
//  FSM states IDLE, REQ, DONE.
//  IDLE:
//   - If any busREQI is set, select the winner and register arbGNT.
//   - Latch the winner's addr/data into arbADDRO/arbDATAO.
//   - Clear timer and go to REQ.
//  REQ:
//   - arbREQO=1 and timer increments each cycle.
//   - arbACKI=1: busDATAO<=arbDATAI, busACKO[arbGNT]<=1 for one cycle, go to DONE.
//   - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: busDATAO<=0, busACKO[arbGNT] pulse,
//     arbNXM pulse, go to DONE.
//   - arbACKI wins over a same-cycle timeout: no NXM is issued.
//  DONE:
//   - arbREQO=0.
//   - Stay here while busREQI[arbGNT]=1, so a master whose request is still asserted
//     cannot be re-granted the same access.
//   - When it drops, go to IDLE; in RR_MODE set rrPtr<=(arbGNT+1) mod NUM_MST.
//  Latency:
//   - busREQI to arbREQO: 1 cycle.
//   - arbACKI to busACKO/busDATAO: 1 cycle (registered).
//   - Minimum transaction length: 3 cycles (IDLE, REQ, DONE).
//  Selection:
//   - Fixed mode: the lowest set index wins.
//   - RR mode: search from rrPtr upward with wrap; the first set bit wins.
//     rrPtr wraps NUM_MST-1 -> 0.
//  Requests and data outside IDLE:
//   - A master dropping busREQI while in REQ does not abort; the cycle completes.
//   - Requests from other masters are ignored outside IDLE (no preemption).
//   - arbADDRO/arbDATAO/busDATAO hold their values until the next latch event.
//   - busDATAO is 0 after an NXM.
//  Timer: a $clog2(TIMEOUT+1)-bit counter that saturates and never wraps.
//
// STRUCTURE
//  Shared package ks10_bus_pkg:
//   - state enum (IDLE/REQ/DONE);
//   - KS10 bus ADDR_W/DATA_W constants;
//   - master index constants (MST_CPU=0, MST_CSL=1, MST_UBA0=2...).
//  One sub-module, ks10_arb_pick:
//   - combinational request vector + rrPtr + mode -> winner index and a valid flag.
//   - Implemented as a rotate, priority-encode, unrotate.
//  FSM, timer, data latches and ACK decode live in the top module.
//
// TESTING
//  1 Single request: RR_MODE=0; busREQI=4'b0010 with addr 36'o000000001000, mem ACK 2
//    cycles later -> arbGNT=1, arbADDRO=36'o1000, busACKO=4'b0010 one cycle, no arbNXM.
//  2 Fixed priority: busREQI=4'b1110 held, repeated -> master 1 granted every time;
//    masters 2 and 3 starve.
//  3 Round-robin: RR_MODE=1; busREQI=4'b1111 held and dropped after each ACK ->
//    grant order 0,1,2,3,0.
//  4 Timeout: TIMEOUT=8, arbACKI never set -> arbNXM and busACKO pulse together
//    8 cycles after arbREQO rises; busDATAO=0.
//  5 Ack/timeout collision: arbACKI high on the timeout cycle -> no arbNXM, busDATAO=arbDATAI.
//  6 Reset in REQ: rst_N low for 1 cycle -> all outputs 0 asynchronously; no ACK;
//    the next grant starts at master 0.

Source files
------------

// File: rtl/ks10_bus_pkg.sv
// KS10 backplane arbiter shared definitions.
// State encoding, bus widths and master slot numbers.
package ks10_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } arb_state_t;

  localparam int KS10_ADDR_W = 36;
  localparam int KS10_DATA_W = 36;

  localparam int MST_CPU  = 0;
  localparam int MST_CSL  = 1;
  localparam int MST_UBA0 = 2;
  localparam int MST_UBA1 = 3;

endpackage

// File: rtl/ks10_arb_pick.sv
// Winner selection for the KS10 bus arbiter.
// Rotate by the pointer, pick lowest set bit, rotate back.
module ks10_arb_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr,
  output logic [IW-1:0] win,
  output logic          valid
);

  logic [IW-1:0] base;
  logic [N-1:0]  rot;
  logic [IW-1:0] enc;
  logic [IW:0]   sum;

  assign base  = rr ? ptr : '0;
  assign valid = |req;

  // Rotate so that the search start sits at bit 0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(base)) % N];
    end
  end

  // Lowest set bit of the rotated vector.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IW'(i);
    end
  end

  assign sum = {1'b0, enc} + {1'b0, base};
  assign win = (sum >= (IW+1)'(N))
             ? IW'(sum - (IW+1)'(N))
             : sum[IW-1:0];

endmodule

// File: rtl/ks10_bus_arb.sv
// KS10 multi-master bus arbiter.
// Grants one master, runs one target cycle, NXM on timeout.
module ks10_bus_arb
  import ks10_bus_pkg::*;
#(
  parameter int NUM_MST = 4,
  parameter int ADDR_W  = KS10_ADDR_W,
  parameter int DATA_W  = KS10_DATA_W,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_N,
  input  logic [NUM_MST-1:0]        busREQI,
  output logic [NUM_MST-1:0]        busACKO,
  input  logic [NUM_MST*ADDR_W-1:0] busADDRI,
  input  logic [NUM_MST*DATA_W-1:0] busDATAI,
  output logic [DATA_W-1:0]         busDATAO,
  output logic                      arbREQO,
  input  logic                      arbACKI,
  output logic [ADDR_W-1:0]         arbADDRO,
  output logic [DATA_W-1:0]         arbDATAO,
  input  logic [DATA_W-1:0]         arbDATAI,
  output logic [$clog2(NUM_MST)-1:0] arbGNT,
  output logic                      arbBUSY,
  output logic                      arbNXM
);

  localparam int IW = $clog2(NUM_MST);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] ptr_nxt;
  logic [TW-1:0] timer;
  logic [IW-1:0] win;
  logic          win_vld;
  logic          tmo;
  logic          rel;

  ks10_arb_pick #(
    .N  (NUM_MST),
    .IW (IW)
  ) u_pick (
    .req   (busREQI),
    .ptr   (rr_ptr),
    .rr    (RR_MODE != 0),
    .win   (win),
    .valid (win_vld)
  );

  assign tmo = (TIMEOUT != 0) && (timer == TLAST);
  assign rel = !busREQI[arbGNT];
  assign ptr_nxt = (arbGNT == IW'(NUM_MST - 1))
                 ? '0 : arbGNT + 1'b1;

  assign arbREQO = (state == REQ);
  assign arbBUSY = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: grant, wait for ack/timeout, wait for release.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (win_vld) state_nxt = REQ;
      REQ:  if (arbACKI || tmo) state_nxt = DONE;
      DONE: if (rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant/data latches, timer, ack and NXM pulses.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      arbGNT   <= '0;
      arbADDRO <= '0;
      arbDATAO <= '0;
      busDATAO <= '0;
      busACKO  <= '0;
      arbNXM   <= 1'b0;
      rr_ptr   <= '0;
      timer    <= '0;
    end else begin
      busACKO <= '0;
      arbNXM  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            arbGNT   <= win;
            arbADDRO <= busADDRI[win*ADDR_W +: ADDR_W];
            arbDATAO <= busDATAI[win*DATA_W +: DATA_W];
            timer    <= '0;
          end
        end
        REQ: begin
          if (timer != '1) timer <= timer + 1'b1;
          if (arbACKI) begin
            busDATAO <= arbDATAI;
            busACKO  <= NUM_MST'(1) << arbGNT;
          end else if (tmo) begin
            busDATAO <= '0;
            busACKO  <= NUM_MST'(1) << arbGNT;
            arbNXM   <= 1'b1;
          end
        end
        DONE: begin
          if (rel && (RR_MODE != 0)) rr_ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ks10_bus_arb.sv
// Bench for ks10_bus_arb: fixed and round-robin instances.
// Directed cases then random transactions against a model.
module tb_ks10_bus_arb;

  localparam int N  = 4;
  localparam int AW = 36;
  localparam int DW = 36;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;

  logic [N-1:0]    req     [2];
  logic [N*AW-1:0] addr_i  [2];
  logic [N*DW-1:0] data_i  [2];
  logic            ack     [2];
  logic [DW-1:0]   ack_d   [2];
  logic [N-1:0]    bus_ack [2];
  logic [DW-1:0]   bus_do  [2];
  logic            arb_req [2];
  logic [AW-1:0]   arb_addr[2];
  logic [DW-1:0]   arb_do  [2];
  logic [1:0]      gnt     [2];
  logic            busy    [2];
  logic            nxm     [2];

  int            passes = 0;
  int            total  = 0;
  int            fails  = 0;
  int            ptr    [2];
  logic [DW-1:0] exp_do [2];

  always #5 clk = ~clk;

  ks10_bus_arb #(
    .NUM_MST(N), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(0), .TIMEOUT(TO)
  ) u_fix (
    .clk(clk), .rst_N(rst_n),
    .busREQI(req[0]), .busACKO(bus_ack[0]),
    .busADDRI(addr_i[0]), .busDATAI(data_i[0]),
    .busDATAO(bus_do[0]), .arbREQO(arb_req[0]),
    .arbACKI(ack[0]), .arbADDRO(arb_addr[0]),
    .arbDATAO(arb_do[0]), .arbDATAI(ack_d[0]),
    .arbGNT(gnt[0]), .arbBUSY(busy[0]),
    .arbNXM(nxm[0])
  );

  ks10_bus_arb #(
    .NUM_MST(N), .ADDR_W(AW), .DATA_W(DW),
    .RR_MODE(1), .TIMEOUT(TO)
  ) u_rr (
    .clk(clk), .rst_N(rst_n),
    .busREQI(req[1]), .busACKO(bus_ack[1]),
    .busADDRI(addr_i[1]), .busDATAI(data_i[1]),
    .busDATAO(bus_do[1]), .arbREQO(arb_req[1]),
    .arbACKI(ack[1]), .arbADDRO(arb_addr[1]),
    .arbDATAO(arb_do[1]), .arbDATAI(ack_d[1]),
    .arbGNT(gnt[1]), .arbBUSY(busy[1]),
    .arbNXM(nxm[1])
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] rnd36();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[35:0];
  endfunction

  // Model: fixed = lowest index; rr = first set from pointer.
  function automatic int pick(input int k,
                              input logic [N-1:0] r);
    int s;
    s = (k == 0) ? 0 : ptr[k];
    for (int j = 0; j < N; j++) begin
      if (r[(s + j) % N]) return (s + j) % N;
    end
    return -1;
  endfunction

  task automatic scramble(input int k);
    for (int i = 0; i < N; i++) begin
      addr_i[k][i*AW +: AW] = rnd36();
      data_i[k][i*DW +: DW] = rnd36();
    end
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_ack"},  bus_ack[k], 0);
    chk({tag, "_bdo"},  bus_do[k], 0);
    chk({tag, "_req"},  arb_req[k], 0);
    chk({tag, "_addr"}, arb_addr[k], 0);
    chk({tag, "_ado"},  arb_do[k], 0);
    chk({tag, "_gnt"},  gnt[k], 0);
    chk({tag, "_busy"}, busy[k], 0);
    chk({tag, "_nxm"},  nxm[k], 0);
  endtask

  // One transaction: d = no-ack cycles before arbACKI,
  // hold = extra cycles the request stays up after ACK.
  task automatic txn(input int k, input logic [N-1:0] r,
                     input int d, input int hold);
    int w;
    int lim;
    logic [DW-1:0] ad;
    chk("idle_busy", busy[k], 0);
    w = pick(k, r);
    req[k] = r;
    @(posedge clk); @(negedge clk);
    chk("gnt",      gnt[k], w);
    chk("arb_addr", arb_addr[k], addr_i[k][w*AW +: AW]);
    chk("arb_data", arb_do[k], data_i[k][w*DW +: DW]);
    chk("arb_req",  arb_req[k], 1);
    lim = (d >= TO) ? TO : d + 1;
    for (int c = 1; c <= lim; c++) begin
      ad = rnd36();
      ack[k]   = (c == d + 1);
      ack_d[k] = ad;
      @(posedge clk); @(negedge clk);
      ack[k] = 1'b0;
      if (c < lim) begin
        chk("early_ack", bus_ack[k], 0);
        chk("req_held",  arb_req[k], 1);
      end else begin
        exp_do[k] = (d >= TO) ? '0 : ad;
        chk("ack",     bus_ack[k], 4'b1 << w);
        chk("nxm",     nxm[k], (d >= TO));
        chk("bus_do",  bus_do[k], exp_do[k]);
      end
    end
    chk("done_req", arb_req[k], 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_busy", busy[k], 1);
      chk("hold_ack",  bus_ack[k], 0);
      chk("hold_gnt",  gnt[k], w);
    end
    req[k] = '0;
    @(posedge clk); @(negedge clk);
    chk("rel_busy", busy[k], 0);
    chk("rel_ack",  bus_ack[k], 0);
    chk("rel_nxm",  nxm[k], 0);
    chk("rel_bdo",  bus_do[k], exp_do[k]);
    if (k == 1) ptr[k] = (w + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; ack[k] = 1'b0; ack_d[k] = '0;
      ptr[k] = 0; exp_do[k] = '0;
      scramble(k);
    end
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, octal address 1000, ack after 2 cycles.
    scramble(0);
    addr_i[0][1*AW +: AW] = 36'o000000001000;
    txn(0, 4'b0010, 2, 0);

    // Fixed priority starves masters 2 and 3.
    for (int i = 0; i < 3; i++) begin
      scramble(0);
      txn(0, 4'b1110, i, 1);
    end

    // Round-robin order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      scramble(1);
      txn(1, 4'b1111, 1, 0);
    end

    // Timeout to NXM, then ack on the timeout cycle.
    scramble(0);
    txn(0, 4'b0100, 20, 0);
    scramble(0);
    txn(0, 4'b1000, TO - 1, 0);
    scramble(1);
    txn(1, 4'b0011, TO, 2);

    // Reset in REQ: async clear, no ACK, pointer back to 0.
    scramble(1);
    req[1] = 4'b1111;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_req", arb_req[1], 1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero(1, "arst");
    req[1] = '0;
    ack[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    ack[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ptr[k] = 0; exp_do[k] = '0;
    end
    @(negedge clk);
    chk("post_rst_ack",  bus_ack[1], 0);
    chk("post_rst_busy", busy[1], 0);
    scramble(1);
    txn(1, 4'b1111, 0, 0);

    // Random traffic on both instances.
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 2; k++) begin
        scramble(k);
        txn(k, 4'($urandom_range(1, 15)),
            int'($urandom_range(0, 10)),
            int'($urandom_range(0, 2)));
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
